// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: initiator-side sequencer for the 4 KB single-port SRAM macro.
//   clk, resetn      : system clock, asynchronous active-low reset
//   req_*            : valid/ready byte request; req_we = 1 selects write
//   rsp_*            : one-entry read response buffer, held until rsp_ready
//   busy             : sequencer is not idle
//   sram_addr/din    : registered macro address and write data
//   sram_write_en    : registered write pulse, WR_CYCLES wide
//   sram_sense_en    : registered sense pulse, SENSE_CYCLES wide
//   sram_dout        : macro read data, captured on the last sense cycle
module sram_access_ctrl #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8,
    parameter int WR_CYCLES    = 2,
    parameter int SENSE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    output logic              sram_write_en,
    output logic              sram_sense_en,
    input  logic [DATA_W-1:0] sram_dout
);
    typedef enum logic [2:0] {IDLE, SETUP, WRITE, RECOVER, SENSE} state_t;
    localparam int MAX_C = (WR_CYCLES > SENSE_CYCLES) ? WR_CYCLES : SENSE_CYCLES;
    localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             we_q, ready_en, accept, last;
    // ready_en keeps req_ready low while in reset and until the first edge after release
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= (state_n == state && state != IDLE) ? cnt + 1'b1 : '0;
            ready_en <= 1'b1;
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? SETUP : IDLE;
            SETUP:   state_n = we_q ? WRITE : SENSE;
            WRITE:   state_n = last ? RECOVER : WRITE;
            RECOVER: state_n = IDLE;
            SENSE:   state_n = last ? IDLE : SENSE;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        req_ready = ready_en && state == IDLE && !rsp_valid;
        accept    = req_valid && req_ready;
        last      = (state == WRITE) ? cnt == CNT_W'(WR_CYCLES - 1) : cnt == CNT_W'(SENSE_CYCLES - 1);
    end
    // Macro strobes are decoded from the next state so they leave a flop aligned with the state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            we_q          <= 1'b0;
            busy          <= 1'b0;
            sram_addr     <= '0;
            sram_din      <= '0;
            sram_write_en <= 1'b0;
            sram_sense_en <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
        end else begin
            busy          <= state_n != IDLE;
            sram_write_en <= state_n == WRITE;
            sram_sense_en <= state_n == SENSE;
            if (accept) begin
                we_q      <= req_we;
                sram_addr <= req_addr;
                if (req_we)
                    sram_din <= req_wdata;
            end
            if (state == SENSE && last) begin
                rsp_rdata <= sram_dout;
                rsp_valid <= 1'b1;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: randomized and directed checks of sram_access_ctrl against a byte-array reference.
module tb_sram_access_ctrl;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [11:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        req_ready, rsp_valid, busy, sram_write_en, sram_sense_en;
    logic [7:0]  rsp_rdata, sram_din, sram_dout;
    logic [11:0] sram_addr;
    logic        b_valid = 1'b0, b_we = 1'b0, b_rready = 1'b0;
    logic [11:0] b_addr = '0;
    logic [7:0]  b_wdata = '0;
    logic        b_ready, b_rvalid, b_busy, b_wen, b_sen;
    logic [7:0]  b_rdata, b_sdin, b_dout;
    logic [11:0] b_saddr;
    logic [7:0]  mem_a [4096];
    logic [7:0]  mem_b [4096];
    logic [7:0]  ref_mem [4096];
    logic [11:0] written [$];
    logic [11:0] cur_addr = '0;
    logic [7:0]  cur_din = '0;
    int checks = 0, errors = 0, cyc = 0, nwr = 0;
    int pulses = 0, run = 0, bad_w = 0, overlap = 0, addr_bad = 0, din_bad = 0;

    sram_access_ctrl u_dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .busy(busy),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_write_en(sram_write_en),
        .sram_sense_en(sram_sense_en), .sram_dout(sram_dout)
    );

    sram_access_ctrl #(.WR_CYCLES(1), .SENSE_CYCLES(3)) u_b (
        .clk(clk), .resetn(resetn), .req_valid(b_valid), .req_ready(b_ready),
        .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(b_rvalid), .rsp_ready(b_rready), .rsp_rdata(b_rdata), .busy(b_busy),
        .sram_addr(b_saddr), .sram_din(b_sdin), .sram_write_en(b_wen),
        .sram_sense_en(b_sen), .sram_dout(b_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural macros: write on a clock edge while write_en is high, drive dout only while sensing
    always @(posedge clk) if (sram_write_en) mem_a[sram_addr] <= sram_din;
    always @(posedge clk) if (b_wen) mem_b[b_saddr] <= b_sdin;
    assign sram_dout = sram_sense_en ? mem_a[sram_addr] : 8'h00;
    assign b_dout    = b_sen ? mem_b[b_saddr] : 8'h00;

    // Pin-level monitor: pulse widths, strobe overlap, address/data stability while busy
    always @(negedge clk) begin
        if (!resetn) begin
            run = 0;
        end else begin
            if (sram_write_en) run++;
            else if (run != 0) begin
                pulses++;
                if (run != 2) bad_w++;
                run = 0;
            end
            if (sram_write_en && sram_sense_en) overlap++;
            if (busy && sram_addr !== cur_addr) addr_bad++;
            if (sram_write_en && sram_din !== cur_din) din_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("ready_timeout", (n < 200) ? 1 : 0, 1);
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("rsp_timeout", (n < 200) ? 1 : 0, 1);
    endtask

    // Present a request and return the cycle in which it is accepted; leaves req_valid high
    task automatic issue(input logic we, input logic [11:0] a, input logic [7:0] d, output int acc);
        req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
        wait_ready();
        acc = cyc;
        cur_addr = a;
        if (we) begin cur_din = d; ref_mem[a] = d; end
        @(negedge clk);
    endtask

    task automatic do_write(input logic [11:0] a, input logic [7:0] d);
        int acc;
        issue(1'b1, a, d, acc);
        req_valid = 1'b0;
        wait_ready();
        chk("wr_ready_latency", cyc - acc, 5);
        nwr++;
    endtask

    task automatic do_read(input logic [11:0] a);
        int acc;
        issue(1'b0, a, 8'($urandom), acc);
        req_valid = 1'b0;
        wait_rsp();
        chk("rd_latency", cyc - acc, 3);
        chk("rd_data", rsp_rdata, ref_mem[a]);
        chk("din_held", sram_din, cur_din);
        rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
        chk("rsp_cleared", rsp_valid, 0);
    endtask

    initial begin
        int acc, hs, n, bad, wn, sn;
        logic [11:0] a;
        #2;
        chk("reset_ctrl", {req_ready, rsp_valid, busy, sram_write_en, sram_sense_en, rsp_rdata}, 0);
        chk("reset_pins", {sram_addr, sram_din}, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1 chk("ready_before_edge", req_ready, 0);
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1);

        do_write(12'h000, 8'hA5);
        do_read(12'h000);
        do_write(12'hFFF, 8'h3C);
        do_write(12'h800, 8'hC3);
        do_read(12'hFFF);
        do_read(12'h800);

        // Backpressure: response held while a write waits behind it
        do_write(12'h123, 8'h5A);
        issue(1'b0, 12'h123, 8'hFF, acc);
        req_valid = 1'b0;
        wait_rsp();
        chk("bp_latency", cyc - acc, 3);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h124; req_wdata = 8'h77;
        bad = 0;
        repeat (10) begin
            if (!(rsp_valid === 1'b1 && rsp_rdata === 8'h5A && req_ready === 1'b0)) bad++;
            @(negedge clk);
        end
        chk("bp_stable", bad, 0);
        rsp_ready = 1'b1; hs = cyc; @(negedge clk); rsp_ready = 1'b0;
        issue(1'b1, 12'h124, 8'h77, acc);
        chk("bp_accept_after_hs", acc - hs, 1);
        req_valid = 1'b0;
        wait_ready();
        nwr++;
        do_read(12'h124);

        // Back-to-back writes with req_valid held high
        hs = -1;
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 12'h010 + 12'(i), 8'(8'h10 + i), acc);
            if (i > 0) chk("b2b_interval", acc - hs, 5);
            hs = acc;
        end
        req_valid = 1'b0;
        wait_ready();
        nwr += 16;
        for (int i = 0; i < 16; i++) do_read(12'h010 + 12'(i));

        // Randomized traffic checked against the byte-array reference
        for (int i = 0; i < 24; i++) begin
            if (written.size() == 0 || $urandom_range(0, 1) == 1) begin
                a = 12'($urandom_range(0, 4095));
                do_write(a, 8'($urandom));
                written.push_back(a);
            end else begin
                do_read(written[$urandom_range(0, written.size() - 1)]);
            end
        end
        chk("pulse_count", pulses, nwr);
        chk("we_width", bad_w, 0);
        chk("strobe_overlap", overlap, 0);
        chk("addr_stable", addr_bad, 0);
        chk("din_stable", din_bad, 0);

        // Reset during the first write_en cycle
        do_write(12'h010, 8'h10);
        issue(1'b1, 12'h0F0, 8'hEE, acc);
        req_valid = 1'b0;
        n = 0;
        while (sram_write_en !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("we_seen", (n < 20) ? 1 : 0, 1);
        resetn = 1'b0;
        #1;
        chk("rst_we_async", sram_write_en, 0);
        chk("rst_mid_ctrl", {req_ready, rsp_valid, busy, sram_write_en, sram_sense_en, rsp_rdata}, 0);
        chk("rst_mid_pins", {sram_addr, sram_din}, 0);
        cur_din = 8'h00;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("ready_after_mid_rst", req_ready, 1);
        do_read(12'h010);

        // WR_CYCLES = 1, SENSE_CYCLES = 3 instance
        b_we = 1'b1; b_addr = 12'h2AA; b_wdata = 8'h55; b_valid = 1'b1;
        n = 0;
        while (b_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("b_ready_timeout", (n < 50) ? 1 : 0, 1);
        acc = cyc; @(negedge clk); b_valid = 1'b0;
        wn = 0; n = 0;
        while (b_ready !== 1'b1 && n < 50) begin
            if (b_wen) wn++;
            @(negedge clk); n++;
        end
        chk("b_we_width", wn, 1);
        chk("b_wr_latency", cyc - acc, 4);
        b_we = 1'b0; b_wdata = 8'hFF; b_valid = 1'b1;
        acc = cyc; @(negedge clk); b_valid = 1'b0;
        sn = 0; n = 0;
        while (b_rvalid !== 1'b1 && n < 50) begin
            if (b_sen) sn++;
            if (b_sen && b_wen) overlap++;
            @(negedge clk); n++;
        end
        chk("b_rd_latency", cyc - acc, 5);
        chk("b_sense_width", sn, 3);
        chk("b_rd_data", b_rdata, 8'h55);
        chk("b_din_held", b_sdin, 8'h55);
        b_rready = 1'b1; @(negedge clk); b_rready = 1'b0;
        chk("b_rsp_cleared", b_rvalid, 0);
        chk("final_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
